// File: rtl/sysbus_pkg.sv
// Shared constants and types for the system-bus memory responder.
// Tag MSB selects read (1) or write (0).
package sysbus_pkg;

  localparam int SYS_LINE_BEATS = 8;
  localparam int SYS_BEAT_W = $clog2(SYS_LINE_BEATS);
  localparam int SYS_TAG_W = 13;
  localparam int TAG_MSB = SYS_TAG_W - 1;

  localparam logic TAG_RD = 1'b1;
  localparam logic TAG_WR = 1'b0;

  typedef enum logic [1:0] {
    IDLE,
    WR_DATA,
    RD_WAIT,
    RD_BURST
  } state_e;

endpackage

// File: rtl/sysbus_mem_array.sv
// Single-port backing store: synchronous write, synchronous read.
// Read data holds until the next read is issued.
module sysbus_mem_array #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 64
) (
  input  logic              clk,
  input  logic              en,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) mem[addr] <= wdata;
      else    rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/sysbus_mem_responder.sv
// Line-sized bus memory endpoint: 8-beat read bursts, 8-beat writes.
// Build option: SYSBUS_CRITICAL_WORD_FIRST_EN (read burst starts at offset).
module sysbus_mem_responder
  import sysbus_pkg::*;
#(
  parameter int BUS_DATA_WIDTH = 64,
  parameter int BUS_TAG_WIDTH  = SYS_TAG_W,
  parameter int LINE_BEATS     = SYS_LINE_BEATS,
  parameter int MEM_ADDR_WIDTH = 16,
  parameter int READ_LATENCY   = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      bus_reqcyc,
  input  logic [BUS_DATA_WIDTH-1:0] bus_req,
  input  logic [BUS_TAG_WIDTH-1:0]  bus_reqtag,
  output logic                      bus_reqack,
  output logic                      bus_respcyc,
  output logic [BUS_DATA_WIDTH-1:0] bus_resp,
  output logic [BUS_TAG_WIDTH-1:0]  bus_resptag,
  input  logic                      bus_respack
);

  localparam int BW = $clog2(LINE_BEATS);
  localparam int LW = MEM_ADDR_WIDTH - BW;
  localparam logic [BW-1:0] LAST = BW'(LINE_BEATS - 1);
  localparam logic [3:0] LAT_INIT = 4'(READ_LATENCY - 1);

  state_e state_q, state_d;

  logic [BW-1:0] cnt_q, cnt_d;
  logic [BW-1:0] off_q, off_d;
  logic [3:0] lat_q, lat_d;
  logic [LW-1:0] line_q, line_d;
  logic [BUS_TAG_WIDTH-1:0] tag_q, tag_d;
  logic respcyc_q, respcyc_d;

  logic mem_en;
  logic mem_we;
  logic [MEM_ADDR_WIDTH-1:0] mem_addr;
  logic [BUS_DATA_WIDTH-1:0] mem_rdata;

  logic [MEM_ADDR_WIDTH-1:0] req_word;
  logic [LW-1:0] req_line;
  logic [BW-1:0] req_off;
  logic [BW-1:0] rd_idx;
  logic [BW-1:0] rd_next;
  logic is_rd;

  assign req_word = bus_req[MEM_ADDR_WIDTH+2:3];
  assign req_line = req_word[MEM_ADDR_WIDTH-1:BW];

`ifdef SYSBUS_CRITICAL_WORD_FIRST_EN
  assign req_off = req_word[BW-1:0];
`else
  assign req_off = '0;
`endif

  assign is_rd = (bus_reqtag[BUS_TAG_WIDTH-1] == TAG_RD);

  // Beat index wraps inside the line; never carries into the line base.
  assign rd_idx  = off_q + cnt_q;
  assign rd_next = rd_idx + 1'b1;

  assign bus_reqack = reset && bus_reqcyc &&
                      (state_q == IDLE || state_q == WR_DATA);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    off_d     = off_q;
    lat_d     = lat_q;
    line_d    = line_q;
    tag_d     = tag_q;
    respcyc_d = respcyc_q;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = {line_q, rd_idx};
    unique case (state_q)
      IDLE: begin
        if (bus_reqack) begin
          tag_d  = bus_reqtag;
          line_d = req_line;
          cnt_d  = '0;
          off_d  = is_rd ? req_off : '0;
          if (!is_rd) begin
            state_d = WR_DATA;
          end else if (READ_LATENCY == 1) begin
            state_d   = RD_BURST;
            respcyc_d = 1'b1;
            mem_en    = 1'b1;
            mem_addr  = {req_line, req_off};
          end else begin
            state_d = RD_WAIT;
            lat_d   = LAT_INIT;
          end
        end
      end
      WR_DATA: begin
        if (bus_reqack) begin
          mem_en   = 1'b1;
          mem_we   = 1'b1;
          mem_addr = {line_q, cnt_q};
          cnt_d    = cnt_q + 1'b1;
          if (cnt_q == LAST) state_d = IDLE;
        end
      end
      RD_WAIT: begin
        lat_d = lat_q - 4'd1;
        // Read issued one cycle ahead so data lands with respcyc.
        if (lat_q <= 4'd1) begin
          lat_d     = '0;
          state_d   = RD_BURST;
          respcyc_d = 1'b1;
          mem_en    = 1'b1;
        end
      end
      RD_BURST: begin
        if (bus_respack) begin
          if (cnt_q == LAST) begin
            state_d   = IDLE;
            respcyc_d = 1'b0;
            cnt_d     = '0;
          end else begin
            cnt_d    = cnt_q + 1'b1;
            mem_en   = 1'b1;
            mem_addr = {line_q, rd_next};
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      off_q     <= '0;
      lat_q     <= '0;
      line_q    <= '0;
      tag_q     <= '0;
      respcyc_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      off_q     <= off_d;
      lat_q     <= lat_d;
      line_q    <= line_d;
      tag_q     <= tag_d;
      respcyc_q <= respcyc_d;
    end
  end

  sysbus_mem_array #(
    .ADDR_W(MEM_ADDR_WIDTH),
    .DATA_W(BUS_DATA_WIDTH)
  ) u_mem (
    .clk  (clk),
    .en   (mem_en),
    .we   (mem_we),
    .addr (mem_addr),
    .wdata(bus_req),
    .rdata(mem_rdata)
  );

  assign bus_respcyc = respcyc_q;
  assign bus_resp    = respcyc_q ? mem_rdata : '0;
  assign bus_resptag = tag_q;

endmodule

// File: tb/tb_sysbus_mem_responder.sv
// Randomized bench for sysbus_mem_responder against a word-array model.
// Follows SYSBUS_CRITICAL_WORD_FIRST_EN the same way as the design build.
module tb_sysbus_mem_responder;

  localparam int RL = 4;

  typedef logic [63:0] line_t [8];
  typedef int bp_t [8];

  logic        clk;
  logic        reset;
  logic        bus_reqcyc;
  logic [63:0] bus_req;
  logic [12:0] bus_reqtag;
  logic        bus_reqack;
  logic        bus_respcyc;
  logic [63:0] bus_resp;
  logic [12:0] bus_resptag;
  logic        bus_respack;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;

  logic [63:0] model_mem [int];

  sysbus_mem_responder dut (
    .clk        (clk),
    .reset      (reset),
    .bus_reqcyc (bus_reqcyc),
    .bus_req    (bus_req),
    .bus_reqtag (bus_reqtag),
    .bus_reqack (bus_reqack),
    .bus_respcyc(bus_respcyc),
    .bus_resp   (bus_resp),
    .bus_resptag(bus_resptag),
    .bus_respack(bus_respack)
  );

  initial clk = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int widx(input logic [63:0] a);
    return int'(a[18:3]);
  endfunction

  // Expected burst order from the address rule and the wrap rule.
  function automatic line_t model_line(input logic [63:0] a);
    line_t r;
    int w = widx(a);
    int base = w & ~7;
    int st = 0;
`ifdef SYSBUS_CRITICAL_WORD_FIRST_EN
    st = w % 8;
`endif
    for (int i = 0; i < 8; i++)
      r[i] = model_mem[base + ((st + i) % 8)];
    return r;
  endfunction

  task automatic req_beat(input logic [63:0] d,
                          input logic [12:0] t,
                          output int acc);
    int n = 0;
    @(negedge clk);
    bus_reqcyc = 1; bus_req = d; bus_reqtag = t;
    #1;
    check("reqack", bus_reqack, 1);
    while (!bus_reqack && n < 50) begin
      @(negedge clk); #1; n++;
    end
    acc = cyc;
    @(posedge clk); #1;
    bus_reqcyc = 0;
  endtask

  task automatic wr_line(input logic [63:0] a,
                         input logic [12:0] t,
                         input line_t d,
                         input bit stall);
    int acc;
    int base = widx(a) & ~7;
    req_beat(a, t, acc);
    for (int i = 0; i < 8; i++) begin
      if (stall) repeat ($urandom_range(0, 2)) @(negedge clk);
      req_beat(d[i], t, acc);
      model_mem[base + i] = d[i];
    end
  endtask

  task automatic rd_burst(input int acc,
                          input logic [12:0] t,
                          input line_t exp,
                          input bp_t bp,
                          input int abort_beat,
                          input bit pend,
                          input logic [63:0] paddr,
                          input logic [12:0] ptag,
                          output int pacc);
    int acked = 0, hold = 0, ncyc = 0;
    int nresp = 0, bsum = 0;
    bit first = 1, stalled = 0, done = 0, aborted = 0;
    logic [63:0] prev = '0;
    pacc = -1;
    for (int i = 0; i < 8; i++) bsum += bp[i];
    while (!done && ncyc < 300) begin
      @(negedge clk);
      ncyc++;
      if (pend && nresp >= 2) begin
        bus_reqcyc = 1; bus_req = paddr; bus_reqtag = ptag;
      end
      if (bus_respcyc && abort_beat == acked) begin
        reset = 0;
        bus_respack = 0;
        #1;
        check("abort_respcyc", bus_respcyc, 0);
        check("abort_resp", bus_resp, 0);
        check("abort_reqack", bus_reqack, 0);
        done = 1; aborted = 1;
      end else if (bus_respcyc) begin
        bus_respack = (hold >= bp[acked]);
        #1;
        nresp++;
        if (first) check("rd_latency", cyc - acc, RL);
        first = 0;
        check("resptag", bus_resptag, t);
        if (stalled) check("resp_hold", bus_resp, prev);
        if (pend) check("reqack_busy", bus_reqack, 0);
        if (bus_respack) begin
          check($sformatf("rd_beat%0d", acked), bus_resp, exp[acked]);
          acked++; hold = 0; stalled = 0;
          if (acked == 8) done = 1;
        end else begin
          hold++; stalled = 1; prev = bus_resp;
        end
      end else begin
        bus_respack = $urandom_range(0, 1);
        #1;
        if (!first) check("resp_gap", bus_respcyc, 1);
      end
    end
    if (!done) check("rd_timeout", acked, 8);
    if (done && !aborted) begin
      @(negedge clk);
      bus_respack = 0;
      #1;
      check("resp_end", bus_respcyc, 0);
      check("resp_cycles", nresp, 8 + bsum);
      if (pend) begin
        check("pend_ack", bus_reqack, 1);
        pacc = cyc;
        @(posedge clk); #1;
        bus_reqcyc = 0;
      end
    end
    bus_respack = 0;
  endtask

  task automatic rd_line(input logic [63:0] a,
                         input logic [12:0] t,
                         input bp_t bp,
                         input int abort_beat);
    int acc, pacc;
    line_t exp = model_line(a);
    req_beat(a, t, acc);
    rd_burst(acc, t, exp, bp, abort_beat, 0, '0, '0, pacc);
  endtask

  function automatic bp_t rand_bp();
    bp_t b;
    for (int i = 0; i < 8; i++)
      b[i] = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
    return b;
  endfunction

  initial begin
    line_t d, exp;
    bp_t z, bpx;
    int acc, pacc;
    logic [63:0] a;
    logic [12:0] pool [6];

    for (int i = 0; i < 8; i++) begin
      z[i] = 0;
      d[i] = 64'h11 * (i + 1);
    end

    reset = 0; bus_reqcyc = 1; bus_req = '0;
    bus_reqtag = '1; bus_respack = 0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_reqack", bus_reqack, 0);
    check("rst_respcyc", bus_respcyc, 0);
    check("rst_resp", bus_resp, 0);
    check("rst_resptag", bus_resptag, 0);
    @(negedge clk);
    bus_reqcyc = 0; reset = 1;

    // write then read back
    wr_line(64'h1000, 13'h0005, d, 0);
    rd_line(64'h1000, 13'h1005, z, -1);

    // backpressure on beats 2 and 5
    bpx = z; bpx[2] = 3; bpx[5] = 3;
    rd_line(64'h1000, 13'h1005, bpx, -1);

    // new read held off during a burst
    exp = model_line(64'h1000);
    req_beat(64'h1000, 13'h1001, acc);
    rd_burst(acc, 13'h1001, exp, z, -1,
             1, 64'h1000, 13'h1002, pacc);
    rd_burst(pacc, 13'h1002, exp, z, -1,
             0, '0, '0, acc);

    // unaligned read
    exp = model_line(64'h1028);
`ifdef SYSBUS_CRITICAL_WORD_FIRST_EN
    check("unaligned_order0", exp[0], 64'h66);
`else
    check("unaligned_order0", exp[0], 64'h11);
`endif
    rd_line(64'h1028, 13'h1003, z, -1);

    // reset during beat 3
    rd_line(64'h1000, 13'h1007, z, 3);
    @(negedge clk);
    reset = 1;
    @(negedge clk); #1;
    check("post_abort_respcyc", bus_respcyc, 0);
    rd_line(64'h1000, 13'h1008, z, -1);

    // aliasing modulo store size
    for (int i = 0; i < 8; i++) d[i] = 64'hA0 + i;
    wr_line(64'h1000 + (64'd1 << 19), 13'h0009, d, 1);
    exp = model_line(64'h1000);
    rd_line(64'h1000, 13'h100A, z, -1);
    check("alias_word0", exp[0], 64'hA0);

    // randomized traffic over a small pool of lines
    for (int j = 0; j < 6; j++) begin
      pool[j] = 13'($urandom);
      a = {$urandom, $urandom};
      a[18:6] = pool[j];
      for (int i = 0; i < 8; i++) d[i] = {$urandom, $urandom};
      wr_line(a, {1'b0, 12'($urandom)}, d, 1);
    end
    for (int n = 0; n < 40; n++) begin
      a = {$urandom, $urandom};
      a[18:6] = pool[$urandom_range(0, 5)];
      if ($urandom_range(0, 2) == 0) begin
        for (int i = 0; i < 8; i++) d[i] = {$urandom, $urandom};
        wr_line(a, {1'b0, 12'($urandom)}, d, 1);
      end else begin
        rd_line(a, {1'b1, 12'($urandom)}, rand_bp(), -1);
      end
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
